// File: rtl/fib_check_pkg.sv
// Shared types for the Fibonacci store checker: FSM state and fail cause codes.
package fib_check_pkg;

  typedef enum logic [1:0] {RUN, PASS, FAIL} chk_state_t;

  typedef enum logic [1:0] {C_NONE, C_MISMATCH, C_TIMEOUT, C_OVERSHOOT} fail_cause_t;

endpackage : fib_check_pkg

// File: rtl/fib_seq_gen.sv
// Fibonacci-style sequence generator: cur is the value expected now, nxt the one after.
module fib_seq_gen #(
  parameter int               WIDTH = 32,
  parameter logic [WIDTH-1:0] SEQ0  = 1,
  parameter logic [WIDTH-1:0] SEQ1  = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             advance,
  output logic [WIDTH-1:0] cur,
  output logic [WIDTH-1:0] nxt
);

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;

  // Shift the pair forward on advance; the sum wraps modulo 2^WIDTH by design.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_a <= SEQ0;
      r_b <= SEQ1;
    end else if (advance) begin
      // NOTE: non-blocking assignments make r_b see the old r_a, so both update from pre-edge values.
      r_a <= r_b;
      r_b <= r_a + r_b;
    end
  end

  assign cur = r_a;
  assign nxt = r_b;

endmodule : fib_seq_gen

// File: rtl/fib_store_checker.sv
// Scoreboard that watches the processor store stream and checks the values written
// into an address window against an on-chip Fibonacci sequence.
module fib_store_checker
  import fib_check_pkg::*;
#(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] SEQ0      = 1,
  parameter logic [WIDTH-1:0] SEQ1      = 2,
  parameter logic [WIDTH-1:0] TARGET    = 55,
  parameter logic [WIDTH-1:0] ADDR_BASE = 32'h0000_0064,
  parameter logic [WIDTH-1:0] ADDR_MASK = 32'hFFFF_FFFC,
  parameter int               TIMEOUT   = 1024,
  parameter int               CNT_W     = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             MemWrite,
  input  logic [WIDTH-1:0] DataAdr,
  input  logic [WIDTH-1:0] WriteData,
  output logic             done,
  output logic             pass,
  output logic [1:0]       fail_cause,
  output logic [CNT_W-1:0] store_count,
  output logic [WIDTH-1:0] expected,
  output logic [WIDTH-1:0] last_data
);

  localparam int TW = $clog2(TIMEOUT) + 1;

  chk_state_t       r_state;
  chk_state_t       w_state_nxt;
  fail_cause_t      r_cause;
  fail_cause_t      w_cause_nxt;
  logic [TW-1:0]    r_timer;
  logic [CNT_W-1:0] r_count;
  logic [WIDTH-1:0] r_last;
  logic             w_hit;
  logic             w_hit_run;
  logic             w_advance;
  logic [WIDTH-1:0] w_cur;
  logic [WIDTH-1:0] w_nxt;

  // Logical AND short-circuits, so an undriven address while MemWrite is low yields no hit.
  assign w_hit     = MemWrite && ((DataAdr & ADDR_MASK) == (ADDR_BASE & ADDR_MASK));
  assign w_hit_run = w_hit && (r_state == RUN);

  fib_seq_gen #(
    .WIDTH (WIDTH),
    .SEQ0  (SEQ0),
    .SEQ1  (SEQ1)
  ) u_seq (
    .clk     (clk),
    .reset   (reset),
    .advance (w_advance),
    .cur     (w_cur),
    .nxt     (w_nxt)
  );

  // State and fail cause register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= RUN;
      r_cause <= C_NONE;
    end else begin
      r_state <= w_state_nxt;
      r_cause <= w_cause_nxt;
    end
  end

  // Next-state decision; a hit always takes priority over timer expiry.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    w_state_nxt = r_state;
    w_cause_nxt = r_cause;
    w_advance   = 1'b0;
    if (r_state == RUN) begin
      if (w_hit) begin
        if (WriteData != w_cur) begin
          w_state_nxt = FAIL;
          w_cause_nxt = C_MISMATCH;
        end else if (w_cur == TARGET) begin
          w_state_nxt = PASS;
        end else begin
          w_advance = 1'b1;
          // nxt becomes the new expected value on this same edge.
          if (w_nxt > TARGET) begin
            w_state_nxt = FAIL;
            w_cause_nxt = C_OVERSHOOT;
          end
        end
      end else if (r_timer == TW'(TIMEOUT - 1)) begin
        w_state_nxt = FAIL;
        w_cause_nxt = C_TIMEOUT;
      end
    end
  end

  // Inactivity timer, store counter and last-data capture; all frozen outside RUN.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_timer <= '0;
      r_count <= '0;
      r_last  <= '0;
    end else if (w_hit_run) begin
      r_timer <= '0;
      r_last  <= WriteData;
      if (r_count != '1) r_count <= r_count + CNT_W'(1);
    end else if (r_state == RUN) begin
      r_timer <= r_timer + TW'(1);
    end
  end

  assign done        = (r_state != RUN);
  assign pass        = (r_state == PASS);
  assign fail_cause  = r_cause;
  assign store_count = r_count;
  assign expected    = w_cur;
  assign last_data   = r_last;

endmodule : fib_store_checker

// File: tb/tb_fib_store_checker.sv
// Bench for fib_store_checker: two instances (default parameters, and TIMEOUT=16 /
// TARGET=50) share one store stream; a cycle-level model of each is compared every cycle.
module tb_fib_store_checker;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        MemWrite = 1'b0;
  logic [31:0] DataAdr = 'x;
  logic [31:0] WriteData = 'x;

  logic        a_done, a_pass, b_done, b_pass;
  logic [1:0]  a_cause, b_cause;
  logic [7:0]  a_cnt, b_cnt;
  logic [31:0] a_exp, a_last, b_exp, b_last;

  int n_checks = 0;
  int n_fail   = 0;

  fib_store_checker u_dut_a (
    .clk (clk), .reset (reset), .MemWrite (MemWrite), .DataAdr (DataAdr),
    .WriteData (WriteData), .done (a_done), .pass (a_pass), .fail_cause (a_cause),
    .store_count (a_cnt), .expected (a_exp), .last_data (a_last)
  );

  fib_store_checker #(.TARGET (32'd50), .TIMEOUT (16)) u_dut_b (
    .clk (clk), .reset (reset), .MemWrite (MemWrite), .DataAdr (DataAdr),
    .WriteData (WriteData), .done (b_done), .pass (b_pass), .fail_cause (b_cause),
    .store_count (b_cnt), .expected (b_exp), .last_data (b_last)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  // st: 0 running, 1 passed, 2 failed. idx indexes the precomputed sequence.
  typedef struct {
    int          st;
    logic [1:0]  cause;
    int          cnt;
    int          idx;
    logic [31:0] last;
    int          idle;
  } mdl_t;

  logic [31:0] fib [0:63];
  mdl_t m_a, m_b;

  initial begin
    fib[0] = 32'd1;
    fib[1] = 32'd2;
    for (int i = 2; i < 64; i++) fib[i] = fib[i-1] + fib[i-2];
  end

  function automatic mdl_t mdl_init();
    mdl_t m;
    m.st = 0; m.cause = 2'd0; m.cnt = 0; m.idx = 0; m.last = 32'd0; m.idle = 0;
    return m;
  endfunction

  function automatic mdl_t mdl_step(mdl_t m, logic [31:0] target, int timeout);
    mdl_t n = m;
    logic hit;
    if (reset === 1'b1) return mdl_init();
    if (m.st != 0) return m;
    hit = (MemWrite === 1'b1) && ((DataAdr & 32'hFFFF_FFFC) == 32'h0000_0064);
    if (hit) begin
      n.cnt  = (m.cnt < 255) ? m.cnt + 1 : 255;
      n.last = WriteData;
      n.idle = 0;
      if (WriteData != fib[m.idx]) begin
        n.st = 2; n.cause = 2'd1;
      end else if (fib[m.idx] == target) begin
        n.st = 1;
      end else begin
        n.idx = m.idx + 1;
        if (fib[n.idx] > target) begin
          n.st = 2; n.cause = 2'd3;
        end
      end
    end else if (m.idle == timeout - 1) begin
      n.st = 2; n.cause = 2'd2;
    end else begin
      n.idle = m.idle + 1;
    end
    return n;
  endfunction

  initial begin
    m_a = mdl_init();
    m_b = mdl_init();
  end

  always @(posedge clk) begin
    m_a <= mdl_step(m_a, 32'd55, 1024);
    m_b <= mdl_step(m_b, 32'd50, 16);
  end

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), required %0d (0x%0h) at %0t",
               name, act, act, req, req, $time);
    end
  endtask

  task automatic check_mdl(input string tag, input mdl_t m, input logic done,
                           input logic pass, input logic [1:0] cause,
                           input logic [7:0] cnt, input logic [31:0] exp,
                           input logic [31:0] last);
    check({tag, ".done"},        {31'd0, done},  {31'd0, m.st != 0});
    check({tag, ".pass"},        {31'd0, pass},  {31'd0, m.st == 1});
    check({tag, ".fail_cause"},  {30'd0, cause}, {30'd0, m.cause});
    check({tag, ".store_count"}, {24'd0, cnt},   32'(m.cnt));
    check({tag, ".expected"},    exp,            fib[m.idx]);
    check({tag, ".last_data"},   last,           m.last);
  endtask

  // Every cycle, away from the active edge, compare both instances to their models.
  always @(negedge clk) begin
    check_mdl("a", m_a, a_done, a_pass, a_cause, a_cnt, a_exp, a_last);
    check_mdl("b", m_b, b_done, b_pass, b_cause, b_cnt, b_exp, b_last);
  end

  // ---------------- stimulus ----------------
  // All tasks start and end on a falling edge.
  task automatic do_reset(input int cycles);
    reset = 1'b1;
    repeat (cycles) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic store(input logic [31:0] adr, input logic [31:0] data);
    MemWrite  = 1'b1;
    DataAdr   = adr;
    WriteData = data;
    @(negedge clk);
    MemWrite  = 1'b0;
    DataAdr   = 'x;
    WriteData = 'x;
  endtask

  task automatic idle(input int cycles);
    repeat (cycles) @(negedge clk);
  endtask

  task automatic store_seq(input int n, input bit with_noise);
    for (int i = 0; i < n; i++) begin
      if (with_noise) store(32'h80, 32'd99);
      store(32'h64, fib[i]);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, ".done"},        {31'd0, a_done}, 32'd0);
    check({tag, ".pass"},        {31'd0, a_pass}, 32'd0);
    check({tag, ".fail_cause"},  {30'd0, a_cause}, 32'd0);
    check({tag, ".store_count"}, {24'd0, a_cnt},  32'd0);
    check({tag, ".expected"},    a_exp,           32'd1);
    check({tag, ".last_data"},   a_last,          32'd0);
  endtask

  initial begin
    @(negedge clk);
    // Scenario 1: full correct sequence ends in PASS.
    do_reset(2);
    check_reset_vals("s1_reset");
    store_seq(9, 1'b0);
    check("s1.pass",        {31'd0, a_pass}, 32'd1);
    check("s1.done",        {31'd0, a_done}, 32'd1);
    check("s1.fail_cause",  {30'd0, a_cause}, 32'd0);
    check("s1.store_count", {24'd0, a_cnt},  32'd9);
    check("s1.expected",    a_exp,           32'd55);
    store(32'h64, 32'd89);
    check("s1.frozen_count", {24'd0, a_cnt}, 32'd9);

    // Scenario 2: mismatch on the third store; later stores are ignored.
    do_reset(1);
    store(32'h64, 32'd1);
    store(32'h64, 32'd2);
    store(32'h64, 32'd4);
    check("s2.done",        {31'd0, a_done}, 32'd1);
    check("s2.pass",        {31'd0, a_pass}, 32'd0);
    check("s2.fail_cause",  {30'd0, a_cause}, 32'd1);
    check("s2.last_data",   a_last,          32'd4);
    check("s2.store_count", {24'd0, a_cnt},  32'd3);
    store(32'h64, 32'd3);
    store(32'h64, 32'd5);
    check("s2.frozen_last",  a_last,         32'd4);
    check("s2.frozen_count", {24'd0, a_cnt}, 32'd3);
    check("s2.frozen_exp",   a_exp,          32'd3);

    // Scenario 3: out-of-window stores interleaved with the correct sequence.
    do_reset(1);
    store_seq(9, 1'b1);
    check("s3.pass",        {31'd0, a_pass}, 32'd1);
    check("s3.store_count", {24'd0, a_cnt},  32'd9);

    // Scenario 4: timeout on the TIMEOUT=16 instance; a hit on the last idle cycle wins.
    do_reset(1);
    idle(15);
    check("s4.no_timeout_15", {31'd0, b_done}, 32'd0);
    store(32'h64, 32'd1);
    check("s4.hit_beats_timeout", {31'd0, b_done}, 32'd0);
    idle(15);
    check("s4.restart_15", {31'd0, b_done}, 32'd0);
    idle(1);
    check("s4.done",       {31'd0, b_done}, 32'd1);
    check("s4.fail_cause", {30'd0, b_cause}, 32'd2);

    // Scenario 5: overshoot on the TARGET=50 instance after the 34 store.
    do_reset(1);
    store_seq(7, 1'b0);
    check("s5.before_34", {31'd0, b_done}, 32'd0);
    store(32'h64, 32'd34);
    check("s5.fail_cause", {30'd0, b_cause}, 32'd3);
    check("s5.expected",   b_exp,            32'd55);
    check("s5.count",      {24'd0, b_cnt},   32'd8);

    // Scenario 6: reset mid-run and after FAIL, then a clean PASS.
    do_reset(1);
    store_seq(3, 1'b0);
    do_reset(1);
    check_reset_vals("s6_midrun");
    store(32'h64, 32'd1);
    store(32'h64, 32'd2);
    store(32'h64, 32'd7);
    check("s6.fail", {30'd0, a_cause}, 32'd1);
    do_reset(1);
    check_reset_vals("s6_after_fail");
    store_seq(9, 1'b0);
    check("s6.pass", {31'd0, a_pass}, 32'd1);

    idle(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required $finish");
    $fatal(1, "watchdog");
  end

endmodule : tb_fib_store_checker
